main_fsm: RTL and testbench

Multicycle control state machine for the ARM datapath: sequences fetch, decode, memory and execute steps, and drives the per-state datapath selects. It sits directly upstream of the condition-check and flag logic. Its RegW, MemW and Branch outputs are the unconditional write and branch requests that the condition logic gates with CondEx. NextPC is combined with the gated branch into PCWrite outside this block.

---
 rtl/main_fsm.sv | 170 +++++++++++++++++
 tb/tb_main_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm
//   Multicycle control state machine for the ARM datapath. It sequences
//   fetch, decode, memory and execute steps and drives the datapath selects
//   for each state. RegW, MemW and Branch are ungated requests. Downstream
//   condition logic qualifies them with CondEx. NextPC is merged with the
//   gated branch into PCWrite outside this block.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset, forces FETCH
//   Op         in   2  Instr[27:26]
//   Funct      in   6  Instr[25:20]; [5] = I, [0] = L/S
//   MemReady   in   1  current memory access completes this cycle
//   IRWrite    out  1  load instruction register
//   AdrSrc     out  1  memory address select (0 = PC, 1 = ALU result reg)
//   ALUSrcA    out  2  ALU A select
//   ALUSrcB    out  2  ALU B select
//   ResultSrc  out  2  result mux select
//   ALUOp      out  1  1 = ALU decoder uses Funct, 0 = add
//   NextPC     out  1  unconditional PC update
//   RegW       out  1  register write request (ungated)
//   MemW       out  1  memory write request (ungated)
//   Branch     out  1  branch request (ungated)
//   Undef      out  1  pulse while in UNKNOWN
//   State      out  4  current state encoding, for debug
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Undef,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_UNKNOWN  = 4'd10;

    logic [3:0] state;
    logic [3:0] state_next;

    // Only I (Funct[5]) and L/S (Funct[0]) steer the sequence. The
    // remaining bits belong to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Op/Funct are only looked at in DECODE and MEMADR.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_next = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_MEMWB:    state_next = S_FETCH;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_UNKNOWN:  state_next = S_FETCH;
            // Codes 11-15 recover to FETCH on the next edge.
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode. Everything is a function of the registered state. The
    // only exception is IRWrite/NextPC in FETCH, which must wait for the
    // instruction word to arrive.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Undef     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                // MemW stays asserted across every stall cycle.
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            S_UNKNOWN: begin
                Undef     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Undef;
    logic [3:0] State;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    //           ALUOp, NextPC, RegW, MemW, Branch, Undef}
    logic [17:0] exp_q[$];

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .Undef     (Undef),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output table for each state, written from the state descriptions.
    function automatic logic [13:0] outs(input logic [3:0] s, input logic mr);
        case (s)
            4'd0:    outs = {mr,   1'b0, 2'b01, 2'b10, 2'b10, 1'b0, mr,   4'b0000};
            4'd1:    outs = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 4'b0000};
            4'd2:    outs = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000};
            4'd3:    outs = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000};
            4'd4:    outs = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 4'b1000};
            4'd5:    outs = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0100};
            4'd6:    outs = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000};
            4'd7:    outs = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 4'b0000};
            4'd8:    outs = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b1000};
            4'd9:    outs = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 4'b0010};
            4'd10:   outs = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0001};
            default: outs = 14'd0;
        endcase
    endfunction

    function automatic logic [17:0] observed();
        observed = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    ALUOp, NextPC, RegW, MemW, Branch, Undef};
    endfunction

    task automatic expect_now(input logic [3:0] st, input logic mr);
        exp_q.push_back({st, outs(st, mr)});
    endtask

    task automatic check(input string tag);
        logic [17:0] e;
        logic [17:0] o;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed output with no expected entry queued", tag);
        end else begin
            e = exp_q.pop_front();
            o = observed();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: observed state=%0d outs=%b expected state=%0d outs=%b",
                       tag, o[17:14], o[13:0], e[17:14], e[13:0]);
            end
        end
    endtask

    // One cycle: drive MemReady, queue the expectation for the current
    // state, compare mid-cycle, then advance past the next rising edge.
    task automatic step(input string tag, input logic [3:0] st, input logic mr);
        MemReady = mr;
        expect_now(st, mr);
        #1;
        check(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        Op       = 2'b00;
        Funct    = 6'b000000;
        MemReady = 1'b1;
        #1;

        // Reset held for three cycles: FETCH decode with MemReady=1
        step("rst0", 4'd0, 1'b1);
        step("rst1", 4'd0, 1'b1);
        step("rst2", 4'd0, 1'b1);
        reset = 1'b1;

        // Data processing, register operand
        step("dp_fetch",  4'd0, 1'b1);
        step("dp_decode", 4'd1, 1'b1);
        step("dp_execr",  4'd6, 1'b1);
        step("dp_aluwb",  4'd8, 1'b1);

        // LDR
        Op = 2'b01; Funct = 6'b011001;
        step("ldr_fetch",   4'd0, 1'b1);
        step("ldr_decode",  4'd1, 1'b1);
        step("ldr_memadr",  4'd2, 1'b1);
        step("ldr_memread", 4'd3, 1'b1);
        step("ldr_memwb",   4'd4, 1'b1);

        // STR with two memory stall cycles
        Funct = 6'b011000;
        step("str_fetch",  4'd0, 1'b1);
        step("str_decode", 4'd1, 1'b1);
        step("str_memadr", 4'd2, 1'b1);
        step("str_stall0", 4'd5, 1'b0);
        step("str_stall1", 4'd5, 1'b0);
        step("str_done",   4'd5, 1'b1);

        // Branch
        Op = 2'b10; Funct = 6'b000000;
        step("b_fetch",  4'd0, 1'b1);
        step("b_decode", 4'd1, 1'b1);
        step("b_branch", 4'd9, 1'b1);

        // Immediate data processing. Op changes in EXECUTEI must be ignored.
        Op = 2'b00; Funct = 6'b100100;
        step("dpi_fetch",  4'd0, 1'b1);
        step("dpi_decode", 4'd1, 1'b1);
        Op = 2'b11;
        step("dpi_execi",  4'd7, 1'b1);
        step("dpi_aluwb",  4'd8, 1'b1);

        // Undefined instruction
        step("und_fetch",   4'd0, 1'b1);
        step("und_decode",  4'd1, 1'b1);
        step("und_unknown", 4'd10, 1'b1);

        // Fetch stall. Op changes during FETCH must be ignored.
        Op = 2'b01; Funct = 6'b011000;
        step("fs_stall0", 4'd0, 1'b0);
        Op = 2'b11;
        step("fs_stall1", 4'd0, 1'b0);
        Op = 2'b01;
        step("fs_stall2", 4'd0, 1'b0);
        step("fs_stall3", 4'd0, 1'b0);
        step("fs_ready",  4'd0, 1'b1);
        step("fs_decode", 4'd1, 1'b1);
        step("fs_memadr", 4'd2, 1'b1);

        // Reset asserted mid-MEMWRITE: takes effect with no clock edge
        MemReady = 1'b0;
        expect_now(4'd5, 1'b0);
        #1;
        check("mw_before_rst");
        reset = 1'b0;
        expect_now(4'd0, 1'b0);
        #1;
        check("mw_async_rst");
        @(posedge clk);
        #1;
        step("rst_hold", 4'd0, 1'b0);
        reset = 1'b1;
        step("post_fetch",  4'd0, 1'b1);
        step("post_decode", 4'd1, 1'b1);
        step("post_memadr", 4'd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
